// File: rtl/usb_bulk_pkg.sv
// Shared constants and read-side state encoding for the bulk endpoint buffers.
package usb_bulk_pkg;

    localparam int MAX_PKT_HS = 512;
    localparam int MAX_PKT_FS = 64;

    typedef enum logic [1:0] {
        RD_IDLE = 2'd0,
        RD_SEND = 2'd1,
        RD_WAIT = 2'd2
    } rd_state_t;

endpackage

// File: rtl/sync_fifo_9b.sv
// 9-bit synchronous FIFO: dual-port RAM whose synchronous read lands directly in a
// one-entry output register, so the head entry is always presented without a bubble.
module sync_fifo_9b #(
    parameter int DEPTH_LOG2 = 11
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [8:0]            push_data,
    output logic                  push_ready,
    input  logic                  pop,
    output logic [8:0]            head,
    output logic                  head_valid,
    output logic [DEPTH_LOG2:0]   level
);

    localparam int LW = DEPTH_LOG2 + 1;
    localparam logic [DEPTH_LOG2:0] FULL_LEVEL = LW'(1 << DEPTH_LOG2);

    logic [8:0]              mem [1 << DEPTH_LOG2];
    logic [DEPTH_LOG2-1:0]   wr_ptr;
    logic [DEPTH_LOG2-1:0]   rd_ptr;
    logic [DEPTH_LOG2:0]     ram_level;
    logic [DEPTH_LOG2:0]     level_next;
    logic                    do_push;
    logic                    do_pop;
    logic                    do_fetch;

    assign do_push    = push & push_ready;
    assign do_pop     = pop & head_valid;
    // Refill the output register whenever it is empty or being drained this cycle.
    assign do_fetch   = (ram_level != '0) && (!head_valid || do_pop);
    assign level_next = level + LW'(do_push) - LW'(do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            ram_level  <= '0;
            level      <= '0;
            push_ready <= 1'b0;
            head_valid <= 1'b0;
            head       <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
            end
            if (do_fetch) begin
                rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
                head   <= mem[rd_ptr];
            end
            ram_level  <= ram_level + LW'(do_push) - LW'(do_fetch);
            level      <= level_next;
            push_ready <= (level_next != FULL_LEVEL);
            if (do_fetch) begin
                head_valid <= 1'b1;
            end else if (do_pop) begin
                head_valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/bulk_in_packet_buffer.sv
// Bulk IN endpoint buffer: stores user AXI-Stream bytes with packet boundaries and
// streams them out one max-size USB packet per IN data phase.
module bulk_in_packet_buffer
    import usb_bulk_pkg::*;
#(
    parameter int HIGH_SPEED  = 1,
    parameter int PACKET_MODE = 1,
    parameter int DEPTH_LOG2  = 11
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tlast,
    input  logic                  blk_in_xfer,
    output logic                  blk_xfer_in_has_data,
    output logic [7:0]            blk_xfer_in_data,
    output logic                  blk_xfer_in_data_valid,
    input  logic                  blk_xfer_in_data_ready,
    output logic                  blk_xfer_in_data_last,
    output logic [DEPTH_LOG2:0]   level
);

    localparam int LW      = DEPTH_LOG2 + 1;
    localparam int MAX_PKT = (HIGH_SPEED != 0) ? MAX_PKT_HS : MAX_PKT_FS;
    localparam logic [DEPTH_LOG2:0] MAX_LEVEL = LW'(MAX_PKT);
    localparam logic [9:0]          LAST_IDX  = 10'(MAX_PKT - 1);

    rd_state_t             state;
    rd_state_t             state_next;
    logic [8:0]            head;
    logic                  head_valid;
    logic                  push;
    logic                  push_last;
    logic                  pop;
    logic                  pop_last;
    logic                  at_last;
    logic                  has_data;
    logic [DEPTH_LOG2:0]   pkt_cnt;
    logic [9:0]            byte_cnt;

    assign push      = s_axis_tvalid & s_axis_tready;
    assign push_last = (PACKET_MODE != 0) && s_axis_tlast;
    assign pop       = blk_xfer_in_data_valid & blk_xfer_in_data_ready;
    assign pop_last  = pop & head[8];
    // Oversize user packets are cut at MAX_PKT; only the final chunk carries tlast.
    assign at_last   = head[8] || (byte_cnt == LAST_IDX);

    sync_fifo_9b #(
        .DEPTH_LOG2(DEPTH_LOG2)
    ) fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (s_axis_tvalid),
        .push_data  ({push_last, s_axis_tdata}),
        .push_ready (s_axis_tready),
        .pop        (pop),
        .head       (head),
        .head_valid (head_valid),
        .level      (level)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            pkt_cnt <= '0;
        end else if ((push && push_last) && !pop_last) begin
            pkt_cnt <= pkt_cnt + LW'(1);
        end else if (!(push && push_last) && pop_last) begin
            pkt_cnt <= pkt_cnt - LW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            has_data <= 1'b0;
        end else begin
            has_data <= ((PACKET_MODE != 0) && (pkt_cnt != '0)) || (level >= MAX_LEVEL);
        end
    end

    always_ff @(posedge clk) begin
        if (rst || state == RD_IDLE) begin
            byte_cnt <= '0;
        end else if (pop && byte_cnt != LAST_IDX) begin
            byte_cnt <= byte_cnt + 10'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RD_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A dropped xfer during SEND abandons the packet; unsent bytes stay queued.
    always_comb begin
        state_next = state;
        case (state)
            RD_IDLE: if (blk_in_xfer) state_next = has_data ? RD_SEND : RD_WAIT;
            RD_SEND: begin
                if (!blk_in_xfer) begin
                    state_next = RD_IDLE;
                end else if (pop && at_last) begin
                    state_next = RD_WAIT;
                end
            end
            RD_WAIT: if (!blk_in_xfer) state_next = RD_IDLE;
            default: state_next = RD_IDLE;
        endcase
    end

    always_comb begin
        blk_xfer_in_data_valid = 1'b0;
        blk_xfer_in_data_last  = 1'b0;
        if (state == RD_SEND) begin
            blk_xfer_in_data_valid = head_valid;
            blk_xfer_in_data_last  = head_valid && at_last;
        end
    end

    assign blk_xfer_in_data     = head[7:0];
    assign blk_xfer_in_has_data = has_data;

endmodule

// File: tb/tb_bulk_in_packet_buffer.sv
// Directed bench for bulk_in_packet_buffer: a high-speed packet-mode instance and a
// full-speed streaming instance share one clock and reset.
module tb_bulk_in_packet_buffer;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [7:0]  s_tdata;
    logic        s_tvalid;
    logic        s_tready;
    logic        s_tlast;
    logic        xfer;
    logic        has_data;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        in_last;
    logic [11:0] level;

    logic [7:0]  fs_tdata;
    logic        fs_tvalid;
    logic        fs_tready;
    logic        fs_tlast;
    logic        fs_xfer;
    logic        fs_has_data;
    logic [7:0]  fs_in_data;
    logic        fs_in_valid;
    logic        fs_in_ready;
    logic        fs_in_last;
    logic [8:0]  fs_level;

    int tests = 0;
    int fails = 0;
    logic [7:0] got_data [2048];
    logic       got_last [2048];

    bulk_in_packet_buffer #(
        .HIGH_SPEED(1), .PACKET_MODE(1), .DEPTH_LOG2(11)
    ) dut (
        .clk                    (clk),
        .rst                    (rst),
        .s_axis_tdata           (s_tdata),
        .s_axis_tvalid          (s_tvalid),
        .s_axis_tready          (s_tready),
        .s_axis_tlast           (s_tlast),
        .blk_in_xfer            (xfer),
        .blk_xfer_in_has_data   (has_data),
        .blk_xfer_in_data       (in_data),
        .blk_xfer_in_data_valid (in_valid),
        .blk_xfer_in_data_ready (in_ready),
        .blk_xfer_in_data_last  (in_last),
        .level                  (level)
    );

    bulk_in_packet_buffer #(
        .HIGH_SPEED(0), .PACKET_MODE(0), .DEPTH_LOG2(8)
    ) dut_fs (
        .clk                    (clk),
        .rst                    (rst),
        .s_axis_tdata           (fs_tdata),
        .s_axis_tvalid          (fs_tvalid),
        .s_axis_tready          (fs_tready),
        .s_axis_tlast           (fs_tlast),
        .blk_in_xfer            (fs_xfer),
        .blk_xfer_in_has_data   (fs_has_data),
        .blk_xfer_in_data       (fs_in_data),
        .blk_xfer_in_data_valid (fs_in_valid),
        .blk_xfer_in_data_ready (fs_in_ready),
        .blk_xfer_in_data_last  (fs_in_last),
        .level                  (fs_level)
    );

    task automatic step(input int k);
        repeat (k) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        step(1);
    endtask

    task automatic write_byte(input bit fs, input logic [7:0] d, input logic l);
        int guard;
        guard = 0;
        if (fs) begin
            fs_tdata = d; fs_tlast = l; fs_tvalid = 1'b1;
        end else begin
            s_tdata = d; s_tlast = l; s_tvalid = 1'b1;
        end
        while (((fs ? fs_tready : s_tready) !== 1'b1) && guard < 200) begin
            step(1);
            guard++;
        end
        if (guard >= 200) begin
            tests++;
            fails++;
            $display("[TB] FAIL write_timeout: tready stayed %b, want 1 for byte %0h",
                     fs ? fs_tready : s_tready, d);
        end else begin
            step(1);
        end
        if (fs) begin
            fs_tvalid = 1'b0; fs_tlast = 1'b0;
        end else begin
            s_tvalid = 1'b0; s_tlast = 1'b0;
        end
    endtask

    task automatic run_xfer(input bit fs, input int abort_after, output int n);
        int guard;
        bit done;
        logic v;
        logic l;
        logic [7:0] d;
        n = 0;
        guard = 0;
        done = 1'b0;
        if (fs) begin
            fs_xfer = 1'b1; fs_in_ready = 1'b1;
        end else begin
            xfer = 1'b1; in_ready = 1'b1;
        end
        while (!done && guard < 2000) begin
            step(1);
            guard++;
            v = fs ? fs_in_valid : in_valid;
            l = fs ? fs_in_last : in_last;
            d = fs ? fs_in_data : in_data;
            if (v === 1'b1) begin
                got_data[n] = d;
                got_last[n] = l;
                n++;
                if (l === 1'b1 || n == abort_after) done = 1'b1;
            end
        end
        if (done) begin
            step(1);
        end else begin
            tests++;
            fails++;
            $display("[TB] FAIL xfer_timeout: %0d bytes seen, want a closing byte", n);
        end
        if (fs) begin
            fs_xfer = 1'b0; fs_in_ready = 1'b0;
        end else begin
            xfer = 1'b0; in_ready = 1'b0;
        end
        step(2);
    endtask

    task automatic test_reset();
        step(1);
        tests++;
        if (s_tready !== 1'b0) begin fails++; $display("[TB] FAIL rst_tready: got %b, want 0", s_tready); end
        tests++;
        if (has_data !== 1'b0 || in_valid !== 1'b0 || in_last !== 1'b0) begin
            fails++;
            $display("[TB] FAIL rst_flags: got has_data/valid/last %b%b%b, want 000", has_data, in_valid, in_last);
        end
        tests++;
        if (in_data !== 8'h00 || level !== 12'd0) begin
            fails++;
            $display("[TB] FAIL rst_data_level: got %0h/%0d, want 0/0", in_data, level);
        end
        rst = 1'b0;
        step(1);
        tests++;
        if (s_tready !== 1'b1 || fs_tready !== 1'b1) begin
            fails++;
            $display("[TB] FAIL rst_tready_rise: got %b/%b, want 1/1", s_tready, fs_tready);
        end
    endtask

    task automatic test_short_packet();
        int n;
        for (int i = 0; i < 100; i++) write_byte(1'b0, 8'(i), i == 99);
        step(3);
        tests++;
        if (has_data !== 1'b1 || level !== 12'd100) begin
            fails++;
            $display("[TB] FAIL short_ready: got has_data %b level %0d, want 1 100", has_data, level);
        end
        run_xfer(1'b0, 0, n);
        tests++;
        if (n !== 100) begin fails++; $display("[TB] FAIL short_len: got %0d, want 100", n); end
        for (int i = 0; i < n; i++) begin
            tests++;
            if (got_data[i] !== 8'(i) || got_last[i] !== (i == 99)) begin
                fails++;
                $display("[TB] FAIL short_byte%0d: got %0h last %b, want %0h last %b",
                         i, got_data[i], got_last[i], 8'(i), i == 99);
            end
        end
        tests++;
        if (has_data !== 1'b0 || level !== 12'd0) begin
            fails++;
            $display("[TB] FAIL short_drained: got has_data %b level %0d, want 0 0", has_data, level);
        end
    endtask

    task automatic test_oversize();
        int n;
        int lens [3] = '{512, 512, 176};
        for (int i = 0; i < 1200; i++) write_byte(1'b0, 8'(i), i == 1199);
        step(3);
        for (int k = 0; k < 3; k++) begin
            run_xfer(1'b0, 0, n);
            tests++;
            if (n !== lens[k]) begin fails++; $display("[TB] FAIL big_len%0d: got %0d, want %0d", k, n, lens[k]); end
            for (int i = 0; i < n; i++) begin
                tests++;
                if (got_data[i] !== 8'(k * 512 + i) || got_last[i] !== (i == lens[k] - 1)) begin
                    fails++;
                    $display("[TB] FAIL big%0d_byte%0d: got %0h last %b, want %0h last %b",
                             k, i, got_data[i], got_last[i], 8'(k * 512 + i), i == lens[k] - 1);
                end
            end
        end
        tests++;
        if (has_data !== 1'b0 || level !== 12'd0) begin
            fails++;
            $display("[TB] FAIL big_drained: got has_data %b level %0d, want 0 0", has_data, level);
        end
    endtask

    task automatic test_fs_stream();
        int n;
        for (int i = 0; i < 63; i++) write_byte(1'b1, 8'(i + 8'h40), i == 10);
        step(3);
        tests++;
        if (fs_has_data !== 1'b0 || fs_level !== 9'd63) begin
            fails++;
            $display("[TB] FAIL fs_63: got has_data %b level %0d, want 0 63", fs_has_data, fs_level);
        end
        write_byte(1'b1, 8'h7f, 1'b0);
        step(3);
        tests++;
        if (fs_has_data !== 1'b1) begin fails++; $display("[TB] FAIL fs_64: got has_data %b, want 1", fs_has_data); end
        run_xfer(1'b1, 0, n);
        tests++;
        if (n !== 64) begin fails++; $display("[TB] FAIL fs_len: got %0d, want 64", n); end
        for (int i = 0; i < n; i++) begin
            tests++;
            if (got_data[i] !== 8'(i + 8'h40) || got_last[i] !== (i == 63)) begin
                fails++;
                $display("[TB] FAIL fs_byte%0d: got %0h last %b, want %0h last %b",
                         i, got_data[i], got_last[i], 8'(i + 8'h40), i == 63);
            end
        end
        tests++;
        if (fs_has_data !== 1'b0 || fs_level !== 9'd0) begin
            fails++;
            $display("[TB] FAIL fs_drained: got has_data %b level %0d, want 0 0", fs_has_data, fs_level);
        end
    endtask

    task automatic test_full();
        apply_reset();
        for (int i = 0; i < 2048; i++) write_byte(1'b0, 8'(i), 1'b0);
        tests++;
        if (s_tready !== 1'b0 || level !== 12'd2048) begin
            fails++;
            $display("[TB] FAIL full_state: got tready %b level %0d, want 0 2048", s_tready, level);
        end
        s_tdata = 8'haa; s_tlast = 1'b0; s_tvalid = 1'b1;
        step(2);
        tests++;
        if (level !== 12'd2048) begin fails++; $display("[TB] FAIL full_ignored: got level %0d, want 2048", level); end
        xfer = 1'b1; in_ready = 1'b0;
        step(1);
        tests++;
        if (in_valid !== 1'b1 || in_data !== 8'h00) begin
            fails++;
            $display("[TB] FAIL full_head: got valid %b data %0h, want 1 00", in_valid, in_data);
        end
        in_ready = 1'b1;
        step(1);
        tests++;
        if (s_tready !== 1'b1 || level !== 12'd2047) begin
            fails++;
            $display("[TB] FAIL full_tready_rise: got tready %b level %0d, want 1 2047", s_tready, level);
        end
        in_ready = 1'b0; xfer = 1'b0;
        step(1);
        s_tvalid = 1'b0;
        tests++;
        if (s_tready !== 1'b0 || level !== 12'd2048) begin
            fails++;
            $display("[TB] FAIL full_refill: got tready %b level %0d, want 0 2048", s_tready, level);
        end
    endtask

    task automatic test_abort();
        int n;
        apply_reset();
        for (int i = 0; i < 100; i++) write_byte(1'b0, 8'(i), i == 99);
        step(3);
        run_xfer(1'b0, 10, n);
        tests++;
        if (n !== 10 || level !== 12'd90) begin
            fails++;
            $display("[TB] FAIL abort_first: got %0d bytes level %0d, want 10 90", n, level);
        end
        for (int i = 0; i < n; i++) begin
            tests++;
            if (got_data[i] !== 8'(i) || got_last[i] !== 1'b0) begin
                fails++;
                $display("[TB] FAIL abort_a_byte%0d: got %0h last %b, want %0h last 0", i, got_data[i], got_last[i], 8'(i));
            end
        end
        run_xfer(1'b0, 0, n);
        tests++;
        if (n !== 90) begin fails++; $display("[TB] FAIL abort_rest_len: got %0d, want 90", n); end
        for (int i = 0; i < n; i++) begin
            tests++;
            if (got_data[i] !== 8'(i + 10) || got_last[i] !== (i == 89)) begin
                fails++;
                $display("[TB] FAIL abort_b_byte%0d: got %0h last %b, want %0h last %b",
                         i, got_data[i], got_last[i], 8'(i + 10), i == 89);
            end
        end
    endtask

    task automatic test_simul_tlast();
        int n;
        int guard;
        bit seen;
        apply_reset();
        for (int i = 0; i < 5; i++) write_byte(1'b0, 8'(8'h10 + i), i == 4);
        write_byte(1'b0, 8'h20, 1'b0);
        step(3);
        xfer = 1'b1; in_ready = 1'b1;
        guard = 0;
        seen = 1'b0;
        while (!seen && guard < 100) begin
            step(1);
            guard++;
            if (in_valid === 1'b1 && in_last === 1'b1) seen = 1'b1;
        end
        tests++;
        if (!seen || in_data !== 8'h14) begin
            fails++;
            $display("[TB] FAIL simul_last_byte: got seen %b data %0h, want 1 14", seen, in_data);
        end
        s_tdata = 8'h21; s_tlast = 1'b1; s_tvalid = 1'b1;
        step(1);
        s_tvalid = 1'b0; s_tlast = 1'b0; xfer = 1'b0; in_ready = 1'b0;
        step(3);
        tests++;
        if (has_data !== 1'b1 || level !== 12'd2) begin
            fails++;
            $display("[TB] FAIL simul_pkt_cnt: got has_data %b level %0d, want 1 2", has_data, level);
        end
        run_xfer(1'b0, 0, n);
        tests++;
        if (n !== 2 || got_data[0] !== 8'h20 || got_data[1] !== 8'h21 || got_last[0] !== 1'b0 || got_last[1] !== 1'b1) begin
            fails++;
            $display("[TB] FAIL simul_second: got %0d bytes %0h/%0h last %b%b, want 2 bytes 20/21 last 01",
                     n, got_data[0], got_data[1], got_last[0], got_last[1]);
        end
        tests++;
        if (has_data !== 1'b0) begin fails++; $display("[TB] FAIL simul_drained: got has_data %b, want 0", has_data); end
    endtask

    task automatic test_reset_mid_send();
        for (int i = 0; i < 20; i++) write_byte(1'b0, 8'(i + 1), i == 19);
        step(3);
        xfer = 1'b1; in_ready = 1'b1;
        step(4);
        tests++;
        if (in_valid !== 1'b1 || in_data !== 8'h04) begin
            fails++;
            $display("[TB] FAIL mid_sending: got valid %b data %0h, want 1 04", in_valid, in_data);
        end
        rst = 1'b1;
        step(1);
        tests++;
        if (in_valid !== 1'b0 || in_last !== 1'b0 || has_data !== 1'b0 || s_tready !== 1'b0) begin
            fails++;
            $display("[TB] FAIL mid_rst_flags: got valid/last/has_data/tready %b%b%b%b, want 0000",
                     in_valid, in_last, has_data, s_tready);
        end
        tests++;
        if (in_data !== 8'h00 || level !== 12'd0) begin
            fails++;
            $display("[TB] FAIL mid_rst_data: got data %0h level %0d, want 00 0", in_data, level);
        end
        rst = 1'b0; xfer = 1'b0; in_ready = 1'b0;
        step(3);
        tests++;
        if (s_tready !== 1'b1 || level !== 12'd0 || has_data !== 1'b0) begin
            fails++;
            $display("[TB] FAIL mid_after: got tready %b level %0d has_data %b, want 1 0 0", s_tready, level, has_data);
        end
    endtask

    initial begin
        rst = 1'b1;
        s_tdata = '0; s_tvalid = 1'b0; s_tlast = 1'b0; xfer = 1'b0; in_ready = 1'b0;
        fs_tdata = '0; fs_tvalid = 1'b0; fs_tlast = 1'b0; fs_xfer = 1'b0; fs_in_ready = 1'b0;
        test_reset();
        test_short_packet();
        test_oversize();
        test_fs_stream();
        test_full();
        test_abort();
        test_simul_tlast();
        test_reset_mid_send();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
